// File: rtl/mat_result_tx.sv
// Serializes a captured 2x2 matrix result into a header + 8 data byte frame on a valid/ready byte stream.
// Optional feature macro: MAT_TX_CKSUM_EN appends an XOR checksum byte (10-byte frame instead of 9).
module mat_result_tx #(
    parameter logic [5:0] HDR_TAG = 6'b101000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] y00,
    input  logic [15:0] y01,
    input  logic [15:0] y10,
    input  logic [15:0] y11,
    input  logic [1:0]  op,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
`ifdef MAT_TX_CKSUM_EN
        ,
        CKSUM
`endif
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [2:0]  idx_reg;
    logic [2:0]  idx_next;
    logic [15:0] y_reg [0:3];
    logic [1:0]  op_reg;
    logic [7:0]  frame_cnt_reg;
    logic [7:0]  frame_cnt_next;
    logic        capture;
    logic        in_ready_idle;
    logic [7:0]  hdr_byte;
    logic [7:0]  data_byte [0:7];

    assign hdr_byte = {HDR_TAG, op_reg};

    // Byte order within the frame: low byte of each element before its high byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign data_byte[2*gi]   = y_reg[gi][7:0];
            assign data_byte[2*gi+1] = y_reg[gi][15:8];
        end
    endgenerate

`ifdef MAT_TX_CKSUM_EN
    logic [7:0] cksum_byte;

    always_comb begin
        cksum_byte = hdr_byte;
        for (int i = 0; i < 8; i++) begin
            cksum_byte = cksum_byte ^ data_byte[i];
        end
    end
`endif

    // Outputs depend only on state, index and captured data, so they hold during stalls.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        frame_cnt_next = frame_cnt_reg;
        capture        = 1'b0;
        in_ready_idle  = 1'b0;
        tx_valid       = 1'b0;
        tx_last        = 1'b0;
        tx_data        = 8'h00;
        case (state_reg)
            IDLE: begin
                in_ready_idle = 1'b1;
                if (in_valid) begin
                    capture    = 1'b1;
                    idx_next   = 3'd0;
                    state_next = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte;
                if (tx_ready) begin
                    idx_next   = 3'd0;
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_data  = data_byte[idx_reg];
`ifdef MAT_TX_CKSUM_EN
                if (tx_ready) begin
                    if (idx_reg == 3'd7) begin
                        idx_next   = 3'd0;
                        state_next = CKSUM;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
`else
                tx_last = (idx_reg == 3'd7);
                if (tx_ready) begin
                    if (idx_reg == 3'd7) begin
                        idx_next       = 3'd0;
                        frame_cnt_next = frame_cnt_reg + 8'd1;
                        state_next     = IDLE;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
`endif
            end
`ifdef MAT_TX_CKSUM_EN
            CKSUM: begin
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                tx_data  = cksum_byte;
                if (tx_ready) begin
                    frame_cnt_next = frame_cnt_reg + 8'd1;
                    state_next     = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset parks the FSM in IDLE; gate in_ready so nothing is offered while reset is held.
    assign in_ready  = in_ready_idle & rst_n;
    assign frame_cnt = frame_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= 3'd0;
            op_reg        <= 2'd0;
            frame_cnt_reg <= 8'd0;
            y_reg[0]      <= 16'd0;
            y_reg[1]      <= 16'd0;
            y_reg[2]      <= 16'd0;
            y_reg[3]      <= 16'd0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            frame_cnt_reg <= frame_cnt_next;
            if (capture) begin
                op_reg   <= op;
                y_reg[0] <= y00;
                y_reg[1] <= y01;
                y_reg[2] <= y10;
                y_reg[3] <= y11;
            end
        end
    end

endmodule

// File: tb/tb_mat_result_tx.sv
// Randomized/directed bench for mat_result_tx against a queue-based frame model.
// Frame length follows MAT_TX_CKSUM_EN the same way the design does.
module tb_mat_result_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] y00 = '0, y01 = '0, y10 = '0, y11 = '0;
    logic [1:0]  op = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        tx_last;
    logic [7:0]  frame_cnt;

    int          total = 0;
    int          passed = 0;
    int          failed = 0;
    logic [7:0]  exp_cnt = 8'd0;

    typedef logic [7:0] bq_t[$];

    mat_result_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .y00      (y00),
        .y01      (y01),
        .y10      (y10),
        .y11      (y11),
        .op       (op),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame: header, the 8 data bytes low-then-high per element, optional XOR of all of them.
    function automatic bq_t mk(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d,
                               input logic [1:0] o);
        bq_t        q;
        logic [15:0] ys [4];
        logic [7:0]  x;
        ys = '{a, b, c, d};
        q.push_back({6'b101000, o});
        foreach (ys[i]) begin
            q.push_back(ys[i][7:0]);
            q.push_back(ys[i][15:8]);
        end
`ifdef MAT_TX_CKSUM_EN
        x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        q.push_back(x);
`else
        x = 8'h00;
`endif
        return q;
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d,
                        input logic [1:0] o);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", in_ready, 1);
        y00 = a; y01 = b; y10 = c; y11 = d; op = o;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_drop", in_ready, 0);
        in_valid = 1'b0;
    endtask

    // mode 0: ready always high, 1: toggles 1/0, 2: random
    task automatic rx_frame(input bq_t q, input int mode, input string tag);
        int         n = 0;
        int         cyc = 0;
        logic       stalled = 1'b0;
        logic [7:0] held = 8'h00;
        while (n < q.size() && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({tag, "_hdr_latency"}, tx_valid, 1);
            if (stalled) begin
                chk({tag, "_stall_data"}, tx_data, held);
                chk({tag, "_stall_valid"}, tx_valid, 1);
            end
            if (mode == 0) tx_ready = 1'b1;
            else if (mode == 1) tx_ready = cyc[0];
            else tx_ready = 1'($urandom_range(0, 1));
            if (tx_valid && tx_ready) begin
                chk({tag, $sformatf("_b%0d", n)}, tx_data, q[n]);
                chk({tag, $sformatf("_last%0d", n)}, tx_last, (n == q.size() - 1));
                n++;
                stalled = 1'b0;
            end else begin
                stalled = tx_valid;
                held    = tx_data;
            end
        end
        chk({tag, "_complete"}, n, q.size());
        @(negedge clk);
        exp_cnt++;
        chk({tag, "_frame_cnt"}, frame_cnt, exp_cnt);
        chk({tag, "_idle_valid"}, tx_valid, 0);
        chk({tag, "_idle_ready"}, in_ready, 1);
        $display("frame %s bytes=%0d frame_cnt=%0d", tag, n, frame_cnt);
    endtask

    initial begin
        logic [15:0] r [4];
        logic [1:0]  ro;

        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Reference frame, continuous ready
        send(16'h1234, 16'h00FF, 16'h8001, 16'h0000, 2'b11);
        rx_frame(mk(16'h1234, 16'h00FF, 16'h8001, 16'h0000, 2'b11), 0, "ref");

        // Same frame with ready toggling
        send(16'h1234, 16'h00FF, 16'h8001, 16'h0000, 2'b11);
        rx_frame(mk(16'h1234, 16'h00FF, 16'h8001, 16'h0000, 2'b11), 1, "toggle");

        // New data offered throughout a frame must wait for the next IDLE
        send(16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0, 2'b01);
        y00 = 16'hDEAD; y01 = 16'hBEEF; y10 = 16'hCAFE; y11 = 16'hF00D; op = 2'b10;
        in_valid = 1'b1;
        rx_frame(mk(16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0, 2'b01), 2, "busy");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rx_frame(mk(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 2'b10), 0, "second");

        // Random frames under random backpressure
        for (int k = 0; k < 6; k++) begin
            foreach (r[i]) r[i] = 16'($urandom);
            ro = 2'($urandom_range(0, 3));
            send(r[0], r[1], r[2], r[3], ro);
            rx_frame(mk(r[0], r[1], r[2], r[3], ro), 2, $sformatf("rand%0d", k));
        end

        // Reset after 4 accepted bytes
        send(16'h1234, 16'h00FF, 16'h8001, 16'h0000, 2'b11);
        tx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 8'd0;
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_tx_last", tx_last, 0);
        chk("midrst_tx_data", tx_data, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_release_ready", in_ready, 1);

        // 256 back-to-back frames wrap the counter
        for (int k = 0; k < 256; k++) begin
            send(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b00);
            rx_frame(mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b00), 0, $sformatf("wrap%0d", k));
        end
        chk("wrap_frame_cnt_zero", frame_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mat_result_tx.md
MAT_RESULT_TX -- requirements
Module: mat_result_tx

Interface
REQ-001 SHALL have parameter HDR_TAG, default 6'b101000, the upper six bits of every frame header byte.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have ports y00, y01, y10, y11, input, 16 bits each, the 2x2 matrix result elements to transmit.
REQ-005 SHALL have port op, input, 2 bits, the ALU operation code, tagged into the header.
REQ-006 SHALL have port in_valid, input, 1 bit; high means the result and op are valid.
REQ-007 SHALL have port in_ready, output, 1 bit; high means the block can capture a result.
REQ-008 SHALL have port tx_data, output, 8 bits, the serialized byte.
REQ-009 SHALL have port tx_valid, output, 1 bit; high means tx_data is valid.
REQ-010 SHALL have port tx_ready, input, 1 bit; high means the sink accepts a byte.
REQ-011 SHALL have port tx_last, output, 1 bit, marking the final byte of a frame.
REQ-012 SHALL have port frame_cnt, output, 8 bits, the count of completed frames.

Function
REQ-013 SHALL run FSM states IDLE, HDR, DATA, CKSUM; in_ready = 1 only in IDLE.
REQ-014 SHALL capture y00..y11 and op on a rising edge with in_valid && in_ready, then enter HDR; the header is on tx_data in the next cycle (1-cycle latency).
REQ-015 SHALL drive the header byte as {HDR_TAG, op_captured}.
REQ-016 SHALL send data bytes in DATA using a 3-bit index 0..7, in order y00[7:0], y00[15:8], y01[7:0], y01[15:8], y10[7:0], y10[15:8], y11[7:0], y11[15:8].
REQ-017 SHALL advance one byte only on a cycle with tx_valid && tx_ready; otherwise tx_data, tx_last and tx_valid are held stable.
REQ-018 SHALL drive tx_valid = 1 in HDR, DATA and CKSUM, and 0 in IDLE.
REQ-019 SHALL return to IDLE after the final byte is accepted; in_ready rises the following cycle, with no overlap between frames.
REQ-020 SHALL ignore y*, op and in_valid while not in IDLE; captured values are unaffected.
REQ-021 SHALL increment frame_cnt by 1 when the final byte is accepted, wrapping modulo 256 (0xFF -> 0x00).
REQ-022 SHALL stall indefinitely with no timeout if tx_ready is held low.

Reset
REQ-023 SHALL, on rst_n low and asynchronously, force state to IDLE, tx_valid = 0, tx_last = 0, tx_data = 0x00, in_ready = 0 while asserted, frame_cnt = 0x00, and the byte index and captured registers to 0.
REQ-024 SHALL, when reset is asserted mid-frame, discard the frame without emitting tx_last and without incrementing frame_cnt; in_ready = 1 on the first cycle after deassertion.

Configuration
REQ-025 SHALL use macro MAT_TX_CKSUM_EN: when defined, DATA index 7 proceeds to CKSUM, which sends one extra byte equal to the XOR of the header and all 8 data bytes, with tx_last on that byte (10-byte frame).
REQ-026 SHALL, when MAT_TX_CKSUM_EN is undefined, omit the CKSUM state and assert tx_last on y11[15:8] (9-byte frame).

Verification
REQ-027 SHALL cover: y00=0x1234, y01=0x00FF, y10=0x8001, y11=0x0000, op=2'b11, tx_ready held 1 -> bytes A3 34 12 FF 00 01 80 00 00, then FB with MAT_TX_CKSUM_EN; tx_last on the final byte; frame_cnt 0 -> 1.
REQ-028 SHALL cover: the same frame with tx_ready toggling 1/0 each cycle -> identical byte sequence, and tx_data stable during every stall cycle.
REQ-029 SHALL cover: in_valid held 1 with new data during a frame -> that data is not captured; the second frame starts only after an IDLE cycle with in_ready = 1.
REQ-030 SHALL cover: rst_n pulsed low after 4 accepted bytes -> tx_valid 0 immediately, frame_cnt 0, and the next capture starts a fresh header.
REQ-031 SHALL cover: 256 back-to-back frames with op=2'b00 and all y = 0xFFFF -> header 0xA0 and data bytes all FF in each frame (checksum 0xA0 with MAT_TX_CKSUM_EN); frame_cnt wraps to 0x00.
